// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Multi-cycle 18-bit multiply/divide unit fed by the register
//                file read ports. It uses shift-add multiplication and
//                restoring unsigned division, one iteration per cycle for
//                WIDTH cycles. A start/busy/done handshake lets the sequencer
//                stall while an operation is in flight.
//  Options     : MULDIV_MULH_EN - when defined, op 2'b11 returns the high
//                half of the product. When undefined, op 2'b11 is illegal:
//                it completes in one cycle with result 0 and no write strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
   parameter int WIDTH      = 18,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clck,
   input  logic                  reset_enable,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [WIDTH-1:0]      operand_a,
   input  logic [WIDTH-1:0]      operand_b,
   input  logic [REG_ADDR_W-1:0] dest_reg,
   output logic                  busy,
   output logic                  done,
   output logic [WIDTH-1:0]      result,
   output logic [REG_ADDR_W-1:0] result_reg,
   output logic                  write_enable
);

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_DIV    = 2'b01;
   localparam logic [1:0] OP_REM    = 2'b10;
   localparam logic [1:0] OP_MULH   = 2'b11;
   localparam logic [4:0] LAST_ITER = 5'(WIDTH - 1);

   // S_BYPASS is the single wait cycle used by divide-by-zero and illegal
   // ops. They skip the iteration phase but still report one cycle after
   // acceptance, and busy stays low throughout.
   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RUN    = 2'b01,
      S_BYPASS = 2'b10,
      S_DONE   = 2'b11
   } state_t;

   state_t                state_q, state_d;
   logic [4:0]            cnt_q, cnt_d;
   logic [1:0]            op_q, op_d;
   logic [WIDTH-1:0]      a_q, a_d;
   logic [WIDTH-1:0]      b_q, b_d;
   logic [REG_ADDR_W-1:0] dest_q, dest_d;
   // MUL: {high partial sum, multiplier shifting out}.
   // DIV: low half holds the dividend shifting out and the quotient shifting in.
   logic [2*WIDTH-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0]      rem_q, rem_d;
   logic [WIDTH-1:0]      result_q, result_d;
   logic [REG_ADDR_W-1:0] result_reg_q, result_reg_d;
   logic                  we_q, we_d;

   logic [WIDTH:0]        mul_sum;
   logic [WIDTH:0]        trial;
   logic [WIDTH-1:0]      trial_sub;
   logic                  trial_ge;
   logic                  special;
   logic [2*WIDTH-1:0]    acc_step;
   logic [WIDTH-1:0]      rem_step;
   logic [WIDTH-1:0]      run_result;
   logic [WIDTH-1:0]      bypass_result;

   // One iteration of the datapath, and the result for the op in flight.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};
      trial     = {rem_q, acc_q[WIDTH-1]};
      trial_ge  = (trial >= {1'b0, b_q});
      trial_sub = trial[WIDTH-1:0] - b_q;
      if (op_q[1] == op_q[0]) begin
         acc_step = {mul_sum, acc_q[WIDTH-1:1]};
         rem_step = rem_q;
      end else begin
         acc_step = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], trial_ge};
         rem_step = trial_ge ? trial_sub : trial[WIDTH-1:0];
      end
      case (op_q)
         OP_MUL:  run_result = acc_step[WIDTH-1:0];
         OP_DIV:  run_result = acc_step[WIDTH-1:0];
         OP_REM:  run_result = rem_step;
`ifdef MULDIV_MULH_EN
         OP_MULH: run_result = acc_step[2*WIDTH-1:WIDTH];
`endif
         default: run_result = {WIDTH{1'b0}};
      endcase
      case (op_q)
         OP_DIV:  bypass_result = {WIDTH{1'b1}};
         OP_REM:  bypass_result = a_q;
         default: bypass_result = {WIDTH{1'b0}};
      endcase
   end

   // Requests that complete without iterating.
   always_comb begin
      special = ((op == OP_DIV) || (op == OP_REM)) && (operand_b == {WIDTH{1'b0}});
`ifndef MULDIV_MULH_EN
      special = special || (op == OP_MULH);
`endif
   end

   // Next-state and datapath-load logic.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      dest_d       = dest_q;
      acc_d        = acc_q;
      rem_d        = rem_q;
      result_d     = result_q;
      result_reg_d = result_reg_q;
      we_d         = we_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (state_q == S_DONE) state_d = S_IDLE;
            if (start) begin
               op_d   = op;
               a_d    = operand_a;
               b_d    = operand_b;
               dest_d = dest_reg;
               cnt_d  = 5'd0;
               rem_d  = {WIDTH{1'b0}};
               // Multiplies shift the multiplier out; divides shift the dividend out.
               acc_d  = (op[1] == op[0]) ? {{WIDTH{1'b0}}, operand_b}
                                         : {{WIDTH{1'b0}}, operand_a};
               state_d = special ? S_BYPASS : S_RUN;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + 5'd1;
            acc_d = acc_step;
            rem_d = rem_step;
            if (cnt_q == LAST_ITER) begin
               state_d      = S_DONE;
               result_d     = run_result;
               result_reg_d = dest_q;
               we_d         = 1'b1;
            end
         end
         S_BYPASS: begin
            state_d      = S_DONE;
            result_d     = bypass_result;
            result_reg_d = dest_q;
            we_d         = (op_q == OP_DIV) || (op_q == OP_REM);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clck) begin
      if (reset_enable) begin
         state_q      <= S_IDLE;
         cnt_q        <= 5'd0;
         op_q         <= 2'b00;
         a_q          <= {WIDTH{1'b0}};
         b_q          <= {WIDTH{1'b0}};
         dest_q       <= {REG_ADDR_W{1'b0}};
         acc_q        <= {(2*WIDTH){1'b0}};
         rem_q        <= {WIDTH{1'b0}};
         result_q     <= {WIDTH{1'b0}};
         result_reg_q <= {REG_ADDR_W{1'b0}};
         we_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         dest_q       <= dest_d;
         acc_q        <= acc_d;
         rem_q        <= rem_d;
         result_q     <= result_d;
         result_reg_q <= result_reg_d;
         we_q         <= we_d;
      end
   end

   assign busy         = (state_q == S_RUN);
   assign done         = (state_q == S_DONE);
   assign write_enable = (state_q == S_DONE) && we_q;
   assign result       = result_q;
   assign result_reg   = result_reg_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Scoreboard bench for muldiv_unit with directed and random
//                operations compared against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
   localparam int W  = 18;
   localparam int RW = 5;

   logic          clck = 1'b0;
   logic          reset_enable;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  operand_a, operand_b;
   logic [RW-1:0] dest_reg;
   logic          busy, done, write_enable;
   logic [W-1:0]  result;
   logic [RW-1:0] result_reg;

   muldiv_unit #(.WIDTH(W), .REG_ADDR_W(RW)) dut (
      .clck         (clck),
      .reset_enable (reset_enable),
      .start        (start),
      .op           (op),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .dest_reg     (dest_reg),
      .busy         (busy),
      .done         (done),
      .result       (result),
      .result_reg   (result_reg),
      .write_enable (write_enable)
   );

   always #5 clck = ~clck;

   typedef struct {
      logic [W-1:0]  res;
      logic [RW-1:0] rd;
      logic          we;
      int            cyc;
      int            nbusy;
   } exp_t;

   exp_t sb[$];
   exp_t got_e;
   int   cyc      = 0;
   int   n_cmp    = 0;
   int   n_err    = 0;
   int   busy_run = 0;

   // Count rising edges so done timing can be checked absolutely.
   always @(posedge clck) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: plain arithmetic on the operands.
   function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic [RW-1:0] d,
                                  input int base);
      exp_t e;
      longint unsigned p;
      p       = longint'(a) * longint'(b);
      e.rd    = d;
      e.we    = 1'b1;
      e.cyc   = base + 19;
      e.nbusy = 18;
      e.res   = '0;
      case (o)
         2'd0: e.res = W'(p);
         2'd1, 2'd2: begin
            if (b == 0) begin
               e.res   = (o == 2'd1) ? {W{1'b1}} : a;
               e.cyc   = base + 2;
               e.nbusy = 0;
            end else begin
               e.res = (o == 2'd1) ? a / b : a % b;
            end
         end
         default: begin
`ifdef MULDIV_MULH_EN
            e.res = W'(p >> W);
`else
            e.res   = '0;
            e.we    = 1'b0;
            e.cyc   = base + 2;
            e.nbusy = 0;
`endif
         end
      endcase
      return e;
   endfunction

   // Monitor: compare every done pulse against the oldest expectation.
   always @(negedge clck) begin
      if (busy) busy_run++;
      else if (!done) busy_run = 0;
      if (done) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: actual done=1 required done=0 (t=%0t)", $time);
         end else begin
            got_e = sb.pop_front();
            check("result",       result,       got_e.res);
            check("result_reg",   result_reg,   got_e.rd);
            check("write_enable", write_enable, got_e.we);
            check("latency_edge", cyc,          got_e.cyc);
            check("busy_cycles",  busy_run,     got_e.nbusy);
         end
         busy_run = 0;
      end
   end

   // Called on a falling edge; the request is sampled at the next rising edge.
   task automatic issue(input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [RW-1:0] d);
      start     = 1'b1;
      op        = o;
      operand_a = a;
      operand_b = b;
      dest_reg  = d;
      sb.push_back(model(o, a, b, d, cyc));
      @(negedge clck);
      start     = 1'b0;
      op        = 2'($urandom);
      operand_a = W'($urandom);
      operand_b = W'($urandom);
      dest_reg  = RW'($urandom);
   endtask

   // Wait for done; optionally pulse start while busy (it must be dropped).
   task automatic wait_done(input bit noise);
      int k = 0;
      while (!done && k < 40) begin
         if (noise && busy && ($urandom_range(0, 3) == 0)) begin
            start     = 1'b1;
            op        = 2'($urandom);
            operand_a = W'($urandom);
            operand_b = W'($urandom);
            dest_reg  = RW'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge clck);
         k++;
      end
      start = 1'b0;
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL done_timeout: actual done=0 required done=1 within 40 cycles (t=%0t)", $time);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual simulation still running required finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen;
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      reset_enable = 1'b1;
      start        = 1'b0;
      op           = 2'b00;
      operand_a    = '0;
      operand_b    = '0;
      dest_reg     = '0;
      repeat (3) @(negedge clck);
      check("reset_busy",         busy,         0);
      check("reset_done",         done,         0);
      check("reset_write_enable", write_enable, 0);
      check("reset_result",       result,       0);
      check("reset_result_reg",   result_reg,   0);
      reset_enable = 1'b0;
      @(negedge clck);

      // Directed operations from the test plan.
      issue(2'd0, 18'd300, 18'd500, 5'd3);  wait_done(1'b0);
      @(negedge clck);
      issue(2'd1, 18'd1000, 18'd7, 5'd4);   wait_done(1'b1);
      issue(2'd2, 18'd1000, 18'd7, 5'd5);   wait_done(1'b1);   // issued in DONE cycle
      @(negedge clck);
      issue(2'd1, 18'd1234, 18'd0, 5'd6);   wait_done(1'b0);
      @(negedge clck);
      issue(2'd2, 18'd1234, 18'd0, 5'd7);   wait_done(1'b0);
      @(negedge clck);
      issue(2'd3, 18'h3FFFF, 18'h3FFFF, 5'd8); wait_done(1'b0);
      @(negedge clck);

      // Reset during iteration 9, with a simultaneous start that must lose.
      start     = 1'b1;
      op        = 2'd0;
      operand_a = W'($urandom);
      operand_b = W'($urandom);
      dest_reg  = 5'd9;
      @(negedge clck);
      start = 1'b0;
      repeat (9) @(negedge clck);
      reset_enable = 1'b1;
      start        = 1'b1;
      op           = 2'd1;
      operand_b    = 18'd5;
      @(negedge clck);
      reset_enable = 1'b0;
      start        = 1'b0;
      check("midrun_reset_busy",         busy,         0);
      check("midrun_reset_done",         done,         0);
      check("midrun_reset_write_enable", write_enable, 0);
      check("midrun_reset_result",       result,       0);
      check("midrun_reset_result_reg",   result_reg,   0);
      seen = 0;
      repeat (25) begin
         @(negedge clck);
         if (done || busy) seen++;
      end
      check("post_reset_quiet", seen, 0);

      // Random operations with random gaps, including back-to-back issue.
      for (int i = 0; i < 60; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 2000));
         if ($urandom_range(0, 7) == 0) rb = '0;
         else rb = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(1, 300));
         repeat ($urandom_range(0, 2)) @(negedge clck);
         issue(ro, ra, rb, RW'($urandom));
         wait_done(1'b1);
      end
      repeat (3) @(negedge clck);
      check("scoreboard_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
